// File: rtl/uart_rx_if.sv
// Byte delivery channel of the UART receiver: one-entry valid/ready handshake.
interface uart_rx_if;
    logic [7:0] rx_data_o;
    logic       rx_valid_o;
    logic       rx_ready_i;

    modport master (output rx_data_o, output rx_valid_o, input rx_ready_i);
    modport slave  (input rx_data_o, input rx_valid_o, output rx_ready_i);
endinterface

// File: rtl/uart_rx_core.sv
// 8N1 LSB-first UART receiver with a one-entry holding register and
// framing/overrun error pulses.
module uart_rx_core #(
    parameter int BAUD = 115200,
    parameter int FREQ = 50_000_000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        rx_i,
    uart_rx_if.master   rx_if,
    output logic        frame_err_o,
    output logic        overrun_o,
    output logic        busy_o
);
    localparam int CLKS_PER_BIT = FREQ / BAUD;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_STOP  = 3'd3;
    localparam logic [2:0] ST_BREAK = 3'd4;

    logic             sync1_r, rxs_r;
    logic [2:0]       state_r, state_nxt_s;
    logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
    logic [2:0]       idx_r, idx_nxt_s;
    logic [7:0]       shift_r, shift_nxt_s;
    logic [7:0]       data_r, data_nxt_s;
    logic             valid_r, valid_nxt_s;
    logic             ferr_r, ovr_r, ovr_nxt_s;
    logic             busy_r;
    logic             stop_ok_s, stop_bad_s;

    // Frame sequencing: start validation, data shifting, stop check, break wait.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        idx_nxt_s   = idx_r;
        shift_nxt_s = shift_r;
        stop_ok_s   = 1'b0;
        stop_bad_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                cnt_nxt_s = '0;
                if (!rxs_r) state_nxt_s = ST_START;
                else        state_nxt_s = ST_IDLE;
            end
            ST_START: begin
                if (cnt_r == HALF_LAST) begin
                    cnt_nxt_s = '0;
                    idx_nxt_s = 3'd0;
                    // A line back high at mid start bit was a glitch.
                    if (!rxs_r) state_nxt_s = ST_DATA;
                    else        state_nxt_s = ST_IDLE;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (cnt_r == BIT_LAST) begin
                    cnt_nxt_s          = '0;
                    shift_nxt_s[idx_r] = rxs_r;
                    if (idx_r == 3'd7) state_nxt_s = ST_STOP;
                    else               idx_nxt_s   = idx_r + 3'd1;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_W'(1);
                end
            end
            ST_STOP: begin
                if (cnt_r == BIT_LAST) begin
                    cnt_nxt_s = '0;
                    if (rxs_r) begin
                        stop_ok_s   = 1'b1;
                        state_nxt_s = ST_IDLE;
                    end else begin
                        stop_bad_s  = 1'b1;
                        state_nxt_s = ST_BREAK;
                    end
                end else begin
                    cnt_nxt_s = cnt_r + CNT_W'(1);
                end
            end
            ST_BREAK: begin
                cnt_nxt_s = '0;
                if (rxs_r) state_nxt_s = ST_IDLE;
                else       state_nxt_s = ST_BREAK;
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = '0;
            end
        endcase
    end

    // Holding register: load on good stop unless full and not draining.
    always_comb begin
        data_nxt_s  = data_r;
        valid_nxt_s = valid_r;
        ovr_nxt_s   = 1'b0;
        if (stop_ok_s) begin
            if (!valid_r || rx_if.rx_ready_i) begin
                data_nxt_s  = shift_r;
                valid_nxt_s = 1'b1;
            end else begin
                ovr_nxt_s = 1'b1;
            end
        end else if (valid_r && rx_if.rx_ready_i) begin
            valid_nxt_s = 1'b0;
        end else begin
            valid_nxt_s = valid_r;
        end
    end

    // State and output registers; sync flops reset to the idle line level.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync1_r <= 1'b1;
            rxs_r   <= 1'b1;
            state_r <= ST_IDLE;
            cnt_r   <= '0;
            idx_r   <= 3'd0;
            shift_r <= 8'h00;
            data_r  <= 8'h00;
            valid_r <= 1'b0;
            ferr_r  <= 1'b0;
            ovr_r   <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            sync1_r <= rx_i;
            rxs_r   <= sync1_r;
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            idx_r   <= idx_nxt_s;
            shift_r <= shift_nxt_s;
            data_r  <= data_nxt_s;
            valid_r <= valid_nxt_s;
            ferr_r  <= stop_bad_s;
            ovr_r   <= ovr_nxt_s;
            busy_r  <= (state_nxt_s != ST_IDLE);
        end
    end

    assign rx_if.rx_data_o  = data_r;
    assign rx_if.rx_valid_o = valid_r;
    assign frame_err_o      = ferr_r;
    assign overrun_o        = ovr_r;
    assign busy_o           = busy_r;
endmodule

// File: tb/tb_uart_rx_core.sv
// Bench for uart_rx_core: frame-level reference model plus per-cycle compare.
module tb_uart_rx_core;
    localparam int CPB = 434;
    localparam int LAT = 4126;

    logic clk = 1'b0;
    logic rst_n, rx, ferr, ovr, busy;
    uart_rx_if bus ();

    uart_rx_core dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .rx_i        (rx),
        .rx_if       (bus),
        .frame_err_o (ferr),
        .overrun_o   (ovr),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at edge %0d", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        int         edge_n;
        logic [7:0] d;
        bit         good;
    } ev_t;

    ev_t        evq[$];
    ev_t        cur_ev;
    logic       exp_valid = 1'b0;
    logic [7:0] exp_data  = 8'h00;
    logic       exp_ferr  = 1'b0;
    logic       exp_ovr   = 1'b0;
    int         busy_start = 0;
    int         busy_end   = 0;
    bit         check_en   = 1'b0;
    bit         loaded;

    int         n_rise = 0, rise_edge = 0, n_ferr = 0, n_ovr = 0;
    logic [7:0] rise_data = 8'h00;
    logic       prev_valid = 1'b0;

    // Compare against the model, then advance the model to the next edge.
    always @(negedge clk) begin
        if (check_en) begin
            chk("valid", bus.rx_valid_o, exp_valid);
            chk("data", bus.rx_data_o, exp_data);
            chk("frame_err", ferr, exp_ferr);
            chk("overrun", ovr, exp_ovr);
            chk("busy", busy, (cyc >= busy_start && cyc < busy_end) ? 1 : 0);
        end
        if (bus.rx_valid_o === 1'b1 && !prev_valid) begin
            n_rise++;
            rise_edge = cyc;
            rise_data = bus.rx_data_o;
        end
        prev_valid = (bus.rx_valid_o === 1'b1);
        if (ferr === 1'b1) n_ferr++;
        if (ovr === 1'b1) n_ovr++;

        if (!rst_n) begin
            exp_valid = 1'b0;
            exp_data  = 8'h00;
            exp_ferr  = 1'b0;
            exp_ovr   = 1'b0;
            evq.delete();
        end else begin
            exp_ferr = 1'b0;
            exp_ovr  = 1'b0;
            loaded   = 1'b0;
            if (evq.size() > 0 && evq[0].edge_n == cyc + 1) begin
                cur_ev = evq.pop_front();
                if (!cur_ev.good) begin
                    exp_ferr = 1'b1;
                end else if (!exp_valid || bus.rx_ready_i) begin
                    exp_data  = cur_ev.d;
                    exp_valid = 1'b1;
                    loaded    = 1'b1;
                end else begin
                    exp_ovr = 1'b1;
                end
            end
            if (!loaded && exp_valid && bus.rx_ready_i) exp_valid = 1'b0;
        end
    end

    task automatic tick(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // A frame's outcome is known when it starts: stop sample LAT edges later.
    task automatic send(logic [7:0] d, bit good_stop, output int e0);
        ev_t ev;
        e0 = cyc;
        ev.edge_n = e0 + LAT;
        ev.d = d;
        ev.good = good_stop;
        evq.push_back(ev);
        busy_start = e0 + 3;
        busy_end   = good_stop ? e0 + LAT : 32'h7fff_ffff;
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            tick(CPB);
        end
        rx = good_stop;
        tick(CPB);
    endtask

    bit rnd_on = 1'b0;
    int e0, r0, f0, o0, h;

    initial begin
        rst_n = 1'b0;
        rx = 1'b1;
        bus.rx_ready_i = 1'b1;
        tick(2);
        check_en = 1'b1;
        rst_n = 1'b1;
        tick(10);

        // Single byte, ready held high.
        r0 = n_rise; f0 = n_ferr; o0 = n_ovr;
        send(8'hA5, 1'b1, e0);
        tick(10);
        chk("a5_rises", n_rise - r0, 1);
        chk("a5_data", rise_data, 8'hA5);
        chk("a5_latency", rise_edge - e0, 4126);
        chk("a5_valid_dropped", bus.rx_valid_o, 1'b0);
        chk("a5_no_flags", (n_ferr - f0) + (n_ovr - o0), 0);

        // Short low glitch on the line.
        r0 = n_rise;
        busy_start = cyc + 3;
        busy_end   = cyc + 220;
        rx = 1'b0;
        tick(100);
        rx = 1'b1;
        tick(300);
        chk("glitch_rises", n_rise - r0, 0);
        chk("glitch_busy", busy, 1'b0);

        // Bad stop bit followed by a held-low line, then a good byte.
        r0 = n_rise; f0 = n_ferr;
        send(8'h3C, 1'b0, e0);
        tick(2000);
        chk("break_busy", busy, 1'b1);
        rx = 1'b1;
        h = cyc;
        busy_end = h + 3;
        tick(20);
        chk("break_ferr", n_ferr - f0, 1);
        chk("break_rises", n_rise - r0, 0);
        send(8'h11, 1'b1, e0);
        tick(10);
        chk("after_break_data", rise_data, 8'h11);

        // Back-to-back frames.
        r0 = n_rise;
        send(8'h00, 1'b1, e0);
        chk("b2b_first", rise_data, 8'h00);
        send(8'hFF, 1'b1, e0);
        tick(10);
        chk("b2b_rises", n_rise - r0, 2);
        chk("b2b_second", rise_data, 8'hFF);

        // Consumer stalled: second byte overruns.
        o0 = n_ovr;
        bus.rx_ready_i = 1'b0;
        send(8'h12, 1'b1, e0);
        send(8'h34, 1'b1, e0);
        tick(20);
        chk("ovr_hold_data", bus.rx_data_o, 8'h12);
        chk("ovr_hold_valid", bus.rx_valid_o, 1'b1);
        chk("ovr_pulses", n_ovr - o0, 1);
        bus.rx_ready_i = 1'b1;
        tick(2);
        chk("ovr_drained", bus.rx_valid_o, 1'b0);

        // Reset in the middle of bit 4 of 0x55 (line high there).
        r0 = n_rise;
        begin
            ev_t ev;
            e0 = cyc;
            ev.edge_n = e0 + LAT;
            ev.d = 8'h55;
            ev.good = 1'b1;
            evq.push_back(ev);
            busy_start = e0 + 3;
            busy_end   = e0 + LAT;
            rx = 1'b0;
            tick(CPB);
            for (int i = 0; i < 4; i++) begin
                rx = ev.d[i];
                tick(CPB);
            end
            rx = 1'b1;
            tick(CPB / 2);
        end
        rst_n = 1'b0;
        busy_end = cyc + 1;
        tick(1);
        rst_n = 1'b1;
        chk("rst_valid", bus.rx_valid_o, 1'b0);
        chk("rst_data", bus.rx_data_o, 8'h00);
        chk("rst_busy", busy, 1'b0);
        tick(50);
        send(8'h77, 1'b1, e0);
        tick(10);
        chk("rst_rises", n_rise - r0, 1);
        chk("rst_then_data", rise_data, 8'h77);

        // Random bytes, gaps and consumer readiness.
        rnd_on = 1'b1;
        fork
            begin
                while (rnd_on) begin
                    bus.rx_ready_i = 1'($urandom_range(0, 1));
                    tick(1);
                end
            end
        join_none
        for (int k = 0; k < 5; k++) begin
            send(8'($urandom_range(0, 255)), 1'b1, e0);
            tick(int'($urandom_range(0, 30)));
        end
        rnd_on = 1'b0;
        tick(2);
        bus.rx_ready_i = 1'b1;
        tick(5);
        chk("final_drained", bus.rx_valid_o, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1);
    end
endmodule
